audio_test_tone_i2s: RTL and testbench

//  Parametrised audio test-pattern source: generates a stereo I2S stream (bit clock, word

---
 rtl/audio_test_tone_i2s_pkg.sv | 20 ++
 rtl/audio_test_tone_i2s_if.sv | 11 +
 rtl/audio_test_tone_i2s_tx_serializer.sv | 89 ++++++++
 rtl/audio_test_tone_i2s.sv | 88 ++++++++
 tb/tb_audio_test_tone_i2s.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/audio_test_tone_i2s_pkg.sv
// Shared constants for the audio test-tone source: pattern mode encodings,
// default I2S geometry and the square-wave amplitude helper.
package audio_test_tone_i2s_pkg;

  typedef enum logic [1:0] {
    MODE_SILENCE = 2'd0,
    MODE_SQUARE  = 2'd1,
    MODE_SAW     = 2'd2,
    MODE_SPLIT   = 2'd3
  } mode_e;

  localparam int I2S_DEFAULT_WIDTH    = 16;
  localparam int I2S_DEFAULT_SCLK_DIV = 4;

  // Square amplitude is a quarter of full scale: 2^(width-2).
  function automatic logic [31:0] square_amp(input int width);
    return 32'd1 << (width - 2);
  endfunction

endpackage

// File: rtl/audio_test_tone_i2s_if.sv
// Pattern-select input and I2S output pins of the test-tone source.
interface audio_test_tone_i2s_if;
  logic [1:0] mode;
  logic       sclk;
  logic       lrclk;
  logic       sdata;
  logic       frameTick;

  modport master (input mode, output sclk, output lrclk, output sdata, output frameTick);
  modport slave  (output mode, input sclk, input lrclk, input sdata, input frameTick);
endinterface

// File: rtl/audio_test_tone_i2s_tx_serializer.sv
// I2S transmitter: bit-clock divider, bit counter, word select and a
// 2W-bit shifter that takes parallel L/R words at each frame start.
module audio_test_tone_i2s_tx_serializer
  import audio_test_tone_i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = I2S_DEFAULT_WIDTH,
  parameter int SCLK_DIV     = I2S_DEFAULT_SCLK_DIV
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic [SAMPLE_WIDTH-1:0] left_i,
  input  logic [SAMPLE_WIDTH-1:0] right_i,
  output logic                    load_o,
  output logic                    sclk_o,
  output logic                    lrclk_o,
  output logic                    sdata_o,
  output logic                    frame_tick_o
);

  localparam int FW = 2 * SAMPLE_WIDTH;
  localparam int DW = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
  localparam int BW = $clog2(FW);

  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [FW-1:0] shift_q, shift_d;
  logic          sclk_q, sclk_d;
  logic          lrclk_q, lrclk_d;
  logic          sdata_q, sdata_d;
  logic          frame_tick_q, frame_tick_d;
  logic          tick_s;
  logic          load_s;

  assign tick_s = (div_q == DW'(SCLK_DIV - 1));
  assign load_s = tick_s && (bit_q == BW'(FW - 1));

  // Next-state logic; sclk and frameTick look one cycle ahead so the
  // registered pins line up with divCnt/bitCnt exactly.
  always_comb begin
    div_d        = div_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    sdata_d      = sdata_q;
    if (tick_s) begin
      div_d   = '0;
      sdata_d = shift_q[FW-1];
      if (load_s) begin
        bit_d   = '0;
        shift_d = {left_i, right_i};
      end else begin
        bit_d   = bit_q + BW'(1);
        shift_d = {shift_q[FW-2:0], 1'b0};
      end
    end else begin
      div_d = div_q + DW'(1);
    end
    sclk_d       = (div_d >= DW'(SCLK_DIV / 2));
    lrclk_d      = (bit_d >= BW'(SAMPLE_WIDTH));
    frame_tick_d = (div_d == DW'(SCLK_DIV - 1)) && (bit_d == BW'(FW - 1));
  end

  // State and output registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      div_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      sclk_q       <= 1'b0;
      lrclk_q      <= 1'b0;
      sdata_q      <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      sclk_q       <= sclk_d;
      lrclk_q      <= lrclk_d;
      sdata_q      <= sdata_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign load_o       = load_s;
  assign sclk_o       = sclk_q;
  assign lrclk_o      = lrclk_q;
  assign sdata_o      = sdata_q;
  assign frame_tick_o = frame_tick_q;

endmodule

// File: rtl/audio_test_tone_i2s.sv
// Stereo I2S test-pattern source: silence, square, sawtooth or split
// (L saw, R square), with the pattern selected once per frame.
module audio_test_tone_i2s
  import audio_test_tone_i2s_pkg::*;
#(
  parameter int          SAMPLE_WIDTH = I2S_DEFAULT_WIDTH,
  parameter int          SCLK_DIV     = I2S_DEFAULT_SCLK_DIV,
  parameter int          TONE_PERIOD  = 48,
  parameter logic [31:0] SAW_STEP     = 32'h0000_0800
) (
  input logic                   clock,
  input logic                   resetN,
  audio_test_tone_i2s_if.master bus
);

  localparam int                    W       = SAMPLE_WIDTH;
  localparam int                    TW      = $clog2(TONE_PERIOD);
  localparam logic [W-1:0]          AMP     = W'(square_amp(W));
  localparam logic [W-1:0]          NEG_AMP = (~AMP) + W'(1);
  localparam logic [W-1:0]          STEP    = W'(SAW_STEP);

  logic [1:0]    mode_q, mode_d;
  logic [TW-1:0] tone_q, tone_d;
  logic [W-1:0]  phase_q, phase_d;
  logic [W-1:0]  square_s;
  logic [W-1:0]  left_s, right_s;
  logic          load_s;

  // Samples are built from the mode captured at this frame start, so a
  // mode change mid-frame only affects the frame loaded next.
  always_comb begin
    mode_d  = mode_q;
    tone_d  = tone_q;
    phase_d = phase_q;
    if (load_s) begin
      mode_d  = bus.mode;
      phase_d = phase_q + STEP;
      if (tone_q == TW'(TONE_PERIOD - 1)) begin
        tone_d = '0;
      end else begin
        tone_d = tone_q + TW'(1);
      end
    end else begin
      mode_d = mode_q;
    end
    if (tone_q < TW'(TONE_PERIOD / 2)) begin
      square_s = AMP;
    end else begin
      square_s = NEG_AMP;
    end
    case (mode_d)
      MODE_SILENCE: begin left_s = '0;      right_s = '0;       end
      MODE_SQUARE:  begin left_s = square_s; right_s = square_s; end
      MODE_SAW:     begin left_s = phase_q;  right_s = phase_q;  end
      MODE_SPLIT:   begin left_s = phase_q;  right_s = square_s; end
      default:      begin left_s = '0;      right_s = '0;       end
    endcase
  end

  // Pattern state; tone and phase keep running whatever the mode.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      mode_q  <= 2'd0;
      tone_q  <= '0;
      phase_q <= '0;
    end else begin
      mode_q  <= mode_d;
      tone_q  <= tone_d;
      phase_q <= phase_d;
    end
  end

  audio_test_tone_i2s_tx_serializer #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .SCLK_DIV     (SCLK_DIV)
  ) u_ser (
    .clock        (clock),
    .resetN       (resetN),
    .left_i       (left_s),
    .right_i      (right_s),
    .load_o       (load_s),
    .sclk_o       (bus.sclk),
    .lrclk_o      (bus.lrclk),
    .sdata_o      (bus.sdata),
    .frame_tick_o (bus.frameTick)
  );

endmodule

// File: tb/tb_audio_test_tone_i2s.sv
// Self-checking bench: frame-level model of the I2S stream compared every
// cycle, plus literal pins on captured left words and on the model itself.
module tb_audio_test_tone_i2s;

  logic clock  = 1'b0;
  logic resetN = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   epoch = 0;
  logic [1:0]  fm [0:63];
  logic [15:0] cap_l = 16'h0000;

  audio_test_tone_i2s_if bus_if ();

  audio_test_tone_i2s #(
    .SAMPLE_WIDTH (16),
    .SCLK_DIV     (4),
    .TONE_PERIOD  (4),
    .SAW_STEP     (32'h0000_0800)
  ) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus_if)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d (epoch %0d): got %0h expected %0h", name, cyc, epoch, act, exp);
    end
  endtask

  // {L,R} for the k-th frame loaded since reset under mode m.
  function automatic logic [31:0] model_frame(input int k, input logic [1:0] m);
    logic [15:0] sq;
    logic [15:0] saw;
    sq  = ((k % 4) < 2) ? 16'h4000 : 16'hC000;
    saw = 16'(k * 2048);
    case (m)
      2'd1:    return {sq, sq};
      2'd2:    return {saw, saw};
      2'd3:    return {saw, sq};
      default: return 32'h0;
    endcase
  endfunction

  // Word transmitted during frame f (frame 0 after reset is empty).
  function automatic logic [31:0] word_of(input int f);
    if (f < 1 || f > 63) return 32'h0;
    return model_frame(f - 1, fm[f]);
  endfunction

  // Bench cycle counter; records the mode seen at each frame-start edge.
  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cyc <= 0;
    end else begin
      if ((cyc % 128) == 127 && ((cyc + 1) / 128) < 64)
        fm[(cyc + 1) / 128] <= bus_if.mode;
      cyc <= cyc + 1;
    end
  end

  // Per-cycle comparison against the model, plus left-word capture.
  always @(negedge clock) begin
    if (resetN && cyc > 0) begin
      int f;
      int b;
      logic [31:0] wcur;
      logic [31:0] wprev;
      logic        sd_e;
      f     = cyc / 128;
      b     = (cyc / 4) % 32;
      wcur  = word_of(f);
      wprev = word_of(f - 1);
      sd_e  = (b == 0) ? wprev[0] : wcur[32 - b];
      check("sclk",      {31'd0, bus_if.sclk},      {31'd0, ((cyc % 4) >= 2)});
      check("lrclk",     {31'd0, bus_if.lrclk},     {31'd0, (b >= 16)});
      check("sdata",     {31'd0, bus_if.sdata},     {31'd0, sd_e});
      check("frameTick", {31'd0, bus_if.frameTick}, {31'd0, ((cyc % 128) == 127)});
      if (cyc == 127) check("first_frameTick", {31'd0, bus_if.frameTick}, 32'd1);
      if (cyc == 2)   check("first_sclk_rise", {31'd0, bus_if.sclk}, 32'd1);
      if (cyc == 64)  check("lrclk_first_high", {31'd0, bus_if.lrclk}, 32'd1);
      if ((cyc % 4) == 2 && b >= 1 && b <= 16) cap_l = {cap_l[14:0], bus_if.sdata};
      if ((cyc % 128) == 70) begin
        if (epoch == 0 && f == 3) check("L_silent_after_midchange", {16'd0, cap_l}, 32'h0000);
        if (epoch == 0 && f == 5) check("L_square_pos",   {16'd0, cap_l}, 32'h4000);
        if (epoch == 0 && f == 7) check("L_square_neg",   {16'd0, cap_l}, 32'hC000);
        if (epoch == 0 && f == 8) check("L_split_saw",    {16'd0, cap_l}, 32'h3800);
        if (epoch == 1 && f == 1) check("L_saw_first",    {16'd0, cap_l}, 32'h0000);
        if (epoch == 1 && f == 2) check("L_saw_second",   {16'd0, cap_l}, 32'h0800);
        if (epoch == 1 && f == 17) check("L_saw_half",    {16'd0, cap_l}, 32'h8000);
        if (epoch == 1 && f == 32) check("L_saw_last",    {16'd0, cap_l}, 32'hF800);
        if (epoch == 1 && f == 33) check("L_saw_wrap",    {16'd0, cap_l}, 32'h0000);
      end
    end
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog at cycle %0d: run did not complete", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) fm[i] = 2'd0;
    bus_if.mode = 2'd0;

    check("model_sq_k0",    model_frame(0, 2'd1),  32'h4000_4000);
    check("model_sq_k2",    model_frame(2, 2'd1),  32'hC000_C000);
    check("model_saw_k1",   model_frame(1, 2'd2),  32'h0800_0800);
    check("model_saw_k32",  model_frame(32, 2'd2), 32'h0000_0000);
    check("model_split_k5", model_frame(5, 2'd3),  32'h2800_4000);

    repeat (2) @(negedge clock);
    check("rst_sclk",  {31'd0, bus_if.sclk},      32'd0);
    check("rst_lrclk", {31'd0, bus_if.lrclk},     32'd0);
    check("rst_sdata", {31'd0, bus_if.sdata},     32'd0);
    check("rst_ftick", {31'd0, bus_if.frameTick}, 32'd0);
    #1 resetN = 1'b1;

    // Silence, then square from bitCnt 10 of frame 3, then split.
    while (cyc < 3 * 128 + 40) @(negedge clock);
    bus_if.mode = 2'd1;
    while (cyc < 7 * 128 + 20) @(negedge clock);
    bus_if.mode = 2'd3;

    // Asynchronous reset at bitCnt 20, while lrclk is high.
    while (cyc < 10 * 128 + 80) @(negedge clock);
    check("pre_rst_lrclk", {31'd0, bus_if.lrclk}, 32'd1);
    #1 resetN = 1'b0;
    #1;
    check("async_rst_sclk",  {31'd0, bus_if.sclk},      32'd0);
    check("async_rst_lrclk", {31'd0, bus_if.lrclk},     32'd0);
    check("async_rst_sdata", {31'd0, bus_if.sdata},     32'd0);
    check("async_rst_ftick", {31'd0, bus_if.frameTick}, 32'd0);
    epoch = 1;
    for (int i = 0; i < 64; i++) fm[i] = 2'd0;
    bus_if.mode = 2'd2;
    repeat (3) @(negedge clock);
    #1 resetN = 1'b1;

    // Sawtooth through one full phase wrap.
    while (cyc < 34 * 128) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
